// File: rtl/hier_reduce_pipe_if.sv
// hier_reduce_pipe_if: input word handshake and single-bit result handshake
interface hier_reduce_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             in_inv;
    logic             in_valid;
    logic             in_ready;
    logic             out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_mode, in_inv, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_mode, in_inv, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/hier_reduce_pipe.sv
// hier_reduce_pipe: OR/AND/XOR/XNOR word reduction with optional invert, carried
// through a DEPTH-stage valid/ready pipeline, plus a saturating count of delivered ones.
// Define HIER_REDUCE_PIPE_VOTE_EN to triplicate the final stage behind a 2-of-3 vote
// and expose a sticky vote_err flag.
module hier_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    hier_reduce_pipe_if.slave  bus,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   ones_cnt
`ifdef HIER_REDUCE_PIPE_VOTE_EN
    ,
    output logic               vote_err
`endif
);
    logic [WIDTH-1:0] word;
    logic             red;
    logic             r;
    logic             stall;
    logic             out_d;
    logic             out_v;
    logic [DEPTH-1:0] sd_next;
    logic [DEPTH-1:0] sv_next;
`ifdef HIER_REDUCE_PIPE_VOTE_EN
    (* dont_touch = "true" *)
`endif
    logic [DEPTH-1:0] sd;
`ifdef HIER_REDUCE_PIPE_VOTE_EN
    (* dont_touch = "true" *)
`endif
    logic [DEPTH-1:0] sv;

    assign word  = bus.in_data;
    assign red   = bus.in_mode == 2'b00 ? |word : bus.in_mode == 2'b01 ? &word : ^word;
    assign r     = red ^ (bus.in_mode == 2'b11) ^ bus.in_inv;
    assign stall = out_v & ~bus.out_ready;

    assign sd_next = DEPTH'({sd, r});
    assign sv_next = DEPTH'({sv, bus.in_valid});

    assign bus.in_ready  = ~stall;
    assign bus.out_data  = out_d;
    assign bus.out_valid = out_v;

    // shift the reduced bit and its valid one stage per cycle; freeze every stage on stall
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sd <= '0;
            sv <= '0;
        end else if (!stall) begin
            sd <= sd_next;
            sv <= sv_next;
        end

`ifdef HIER_REDUCE_PIPE_VOTE_EN
    (* dont_touch = "true" *) logic d1, d2, v1, v2;
    logic [2:0] cd;
    logic [2:0] cv;

    // copies 1 and 2 of the final stage load exactly what the final bit of sd/sv loads
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (!stall) begin
            d1 <= sd_next[DEPTH-1];
            d2 <= sd_next[DEPTH-1];
            v1 <= sv_next[DEPTH-1];
            v2 <= sv_next[DEPTH-1];
        end

    assign cd    = {d2, d1, sd[DEPTH-1]};
    assign cv    = {v2, v1, sv[DEPTH-1]};
    assign out_d = (cd[0] & cd[1]) | (cd[0] & cd[2]) | (cd[1] & cd[2]);
    assign out_v = (cv[0] & cv[1]) | (cv[0] & cv[2]) | (cv[1] & cv[2]);

    // sticky disagreement flag between any copy and the voted result
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) vote_err <= 1'b0;
        else if (clr_cnt) vote_err <= 1'b0;
        else if (cd != {3{out_d}} || cv != {3{out_v}}) vote_err <= 1'b1;
`else
    assign out_d = sd[DEPTH-1];
    assign out_v = sv[DEPTH-1];
`endif

    // count delivered ones without wrapping; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ones_cnt <= '0;
        else if (clr_cnt) ones_cnt <= '0;
        else if (out_v && bus.out_ready && out_d && ones_cnt != '1) ones_cnt <= ones_cnt + 1'b1;
endmodule

// File: doc/hier_reduce_pipe.md
Name: hier_reduce_pipe

Overview:
Parametrised, pipelined successor to the two-stage reduce/invert hierarchy.
- Reduces a WIDTH-bit input word to one bit using a run-time selectable operator (OR/AND/XOR), optionally inverts it, and carries it through DEPTH register stages under a valid/ready handshake.
- Keeps a saturating count of accepted results equal to 1.
- Sits between a wide status bus and a single-bit flag consumer; used as a TMR triplication/voting test vehicle.

Parameters:
WIDTH, 8, input word width (>=1)
DEPTH, 2, pipeline register stages from accept to out_data (>=1)
CNT_W, 8, width of ones counter (>=1)

Ports:
clk  input  1  clock, all state rising-edge
rstn  input  1  asynchronous active-low reset
in_data  input  WIDTH  word to reduce
in_mode  input  2  00=OR, 01=AND, 10=XOR, 11=XNOR (inverted XOR)
in_inv  input  1  invert reduced bit before stage 1
in_valid  input  1  in_data/in_mode/in_inv valid
in_ready  output  1  pipeline can accept this cycle
out_data  output  1  result bit
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
ones_cnt  output  CNT_W  saturating count of results==1 delivered
clr_cnt  input  1  synchronous clear of ones_cnt

Behaviour:
- Reset (rstn=0, async): all stage data=0, all stage valids=0, out_data=0, out_valid=0, ones_cnt=0. in_ready=1 once reset is released (combinational, see below).
- Reduction is combinational on in_data. r = op(in_data) ^ in_inv; mode 11 gives ~^in_data before in_inv is applied.
- Stall condition: stall = out_valid & ~out_ready. in_ready = ~stall.
- Accept: transfer when in_valid & in_ready.
- Pipeline advance when ~stall:
  - stage1 <= {in_valid, r}.
  - stage k <= stage k-1 for k = 2..DEPTH.
  - Bubbles (valid=0) propagate normally; there is no bubble collapsing.
- When stall: all stages hold.
- Latency: DEPTH cycles from accept to out_valid, with no backpressure. Throughput is 1 result per cycle.
- out_data/out_valid = stage DEPTH. out_data is held stable while out_valid & ~out_ready.
- Output transfer: out_valid & out_ready.
  - If out_data=1, ones_cnt increments.
  - ones_cnt saturates at 2^CNT_W-1 and does not wrap.
- clr_cnt=1 forces ones_cnt to 0 on the next edge and takes priority over a simultaneous increment.
- in_valid=0 with ~stall: a bubble enters stage 1; the prior contents still advance.
- in_valid=1 while stall: the word is not accepted; the source must hold it (valid/ready rule: data stable until accepted).
- Reset asserted mid-operation: all in-flight results are discarded and the count is cleared immediately.
- WIDTH=1: OR/AND pass the bit through, XOR passes the bit through, XNOR inverts it.

Optional Feature:
Macro HIER_REDUCE_PIPE_VOTE_EN.
- Defined:
  - Final stage is triplicated (three copies of data+valid, each loaded identically).
  - out_data/out_valid are the 2-of-3 majority of the copies.
  - Extra output port vote_err (1 bit) is added. It is sticky, set when any copy disagrees with the majority, and cleared by reset or clr_cnt.
  - Copies are marked do_not_touch for the triplicator.
  - Latency is unchanged.
- Undefined: single final stage and no vote_err port. Behaviour is otherwise identical.

Test Plan:
- Reset release, DEPTH=2, in_valid=0 -> out_valid=0, out_data=0, ones_cnt=0, in_ready=1.
- in_data=8'h00, mode=00, inv=0, out_ready=1 held high -> out_data=0 exactly 2 cycles after accept. Then in_data=8'h10 -> out_data=1 and ones_cnt=1.
- Back-to-back 4 words, OR/AND/XOR/XNOR on 8'hFF, inv=0, out_ready=1 -> outputs 1,1,0,1 on consecutive cycles, ones_cnt=3.
- out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, out_data stable, no word lost. Release gives an in-order stream.
- CNT_W=2, 5 results of 1 -> ones_cnt saturates at 3. clr_cnt pulse concurrent with a 1-result -> ones_cnt=0.
- rstn low mid-stream with 2 words in flight -> out_valid=0 immediately, ones_cnt=0. Words are not delivered after release.
- With HIER_REDUCE_PIPE_VOTE_EN: force one copy to flip -> out_data keeps the majority value, vote_err=1 until clr_cnt.
